// File: rtl/h80bus_master_if.sv
// ---------------------------------------------------------------------------
// h80bus_master_if
//
// Purpose:
//   Bundles the request/response handshake between the CPU load/store unit
//   and the h80 bus master, together with the master's bus control outputs
//   and the responder's wait_n stall line.
//
//   The tri-state data bus (data_) is kept out of this bundle. It is a plain
//   inout port on h80bus_master, so the master and responder drivers resolve
//   on one ordinary wire.
//
// Signals:
//   req_valid / req_ready   request handshake (core -> master)
//   req_write, req_word     request kind (1=write / 1=word access)
//   req_addr, req_wdata     request address and write data
//   rsp_valid               one-cycle completion strobe (master -> core)
//   rsp_rdata, rsp_err      read data and timeout flag, valid with rsp_valid
//   ce_n, addr, cmd         bus chip enable (active low), address, command
//   wait_n                  responder stall, active low
//
// Modports:
//   master  the h80bus_master side
//   slave   the opposite side (core plus bus responder)
// ---------------------------------------------------------------------------
interface h80bus_master_if #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic                      req_word;
    logic [BUS_ADDR_WIDTH-1:0] req_addr;
    logic [BUS_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic [BUS_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      ce_n;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_CMD_WIDTH-1:0]  cmd;
    logic                      wait_n;

    modport master (
        input  req_valid, req_write, req_word, req_addr, req_wdata, wait_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ce_n, addr, cmd
    );

    modport slave (
        output req_valid, req_write, req_word, req_addr, req_wdata, wait_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ce_n, addr, cmd
    );
endinterface

// File: rtl/h80bus_master.sv
// ---------------------------------------------------------------------------
// h80bus_master
//
// Purpose:
//   Bus initiator for the h80 peripheral bus. Takes one read/write request
//   at a time from the core, runs a bus access (ADDR then ACCESS, stretched
//   while wait_n is low), and returns read data or write completion on a
//   one-cycle rsp_valid strobe.
//
// Ports:
//   clk     system clock, all logic on posedge
//   reset   asynchronous, active-high reset
//   bus     h80bus_master_if.master: request/response handshake and bus
//           control (ce_n, addr, cmd, wait_n)
//   data_   tri-state bus data. The master drives it only while ce_n is low
//           and cmd[0] is 0 (write).
//
// Configuration:
//   H80BUS_MASTER_TIMEOUT_EN  when defined, an access stalled by wait_n for
//           TIMEOUT_CYCLES cycles is aborted with rsp_err=1 and rsp_rdata=0.
//           When not defined, the master waits indefinitely and rsp_err is
//           always 0.
// ---------------------------------------------------------------------------
module h80bus_master #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    h80bus_master_if.master           bus,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_
);

    // Bus command encodings. Bit 0 set marks a read, so the data_ direction
    // can be decided from cmd alone.
    localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ_B  = BUS_CMD_WIDTH'(3'b001);
    localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE_B = BUS_CMD_WIDTH'(3'b010);
    localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ_W  = BUS_CMD_WIDTH'(3'b011);
    localparam logic [BUS_CMD_WIDTH-1:0] BUS_CMD_WRITE_W = BUS_CMD_WIDTH'(3'b100);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS,
        RESP
    } state_t;

    state_t                    state_q;
    logic                      ceN_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_CMD_WIDTH-1:0]  cmd_q;
    logic [BUS_DATA_WIDTH-1:0] wdata_q;
    logic                      reqReady_q;
    logic                      rspValid_q;
    logic [BUS_DATA_WIDTH-1:0] rdata_q;

    logic [BUS_CMD_WIDTH-1:0]  cmd_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_d;
    logic [BUS_DATA_WIDTH-1:0] rdata_d;

`ifdef H80BUS_MASTER_TIMEOUT_EN
    // The stall counter is at least 8 bits wide, and wide enough to hold
    // TIMEOUT_CYCLES.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stallCount_q;
    logic             rspErr_q;
`endif

    // Translate the request kind into a bus command. Byte writes keep only
    // the low byte of the data, so the upper data lanes are driven as zero.
    always_comb begin
        cmd_d   = BUS_CMD_READ_B;
        wdata_d = bus.req_wdata;
        unique case ({bus.req_write, bus.req_word})
            2'b00: cmd_d = BUS_CMD_READ_B;
            2'b01: cmd_d = BUS_CMD_READ_W;
            2'b10: begin
                cmd_d   = BUS_CMD_WRITE_B;
                wdata_d = {{(BUS_DATA_WIDTH-8){1'b0}}, bus.req_wdata[7:0]};
            end
            default: cmd_d = BUS_CMD_WRITE_W;
        endcase
    end

    // Read data as it will be captured at the end of ACCESS. A byte read
    // zero-extends the low lane. data_ feeds only this value, which goes
    // into rdata_q, so a floating bus cannot disturb the control state.
    always_comb begin
        rdata_d = data_;
        if (cmd_q == BUS_CMD_READ_B) begin
            rdata_d = {{(BUS_DATA_WIDTH-8){1'b0}}, data_[7:0]};
        end
    end

    // Access sequencer. All bus and handshake outputs are registered here.
    // Reset forces ce_n high and clears cmd asynchronously, which releases
    // data_ immediately and drops any access in flight without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ceN_q        <= 1'b1;
            addr_q       <= '0;
            cmd_q        <= '0;
            wdata_q      <= '0;
            reqReady_q   <= 1'b1;
            rspValid_q   <= 1'b0;
            rdata_q      <= '0;
`ifdef H80BUS_MASTER_TIMEOUT_EN
            stallCount_q <= '0;
            rspErr_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid && reqReady_q) begin
                        addr_q     <= bus.req_addr;
                        cmd_q      <= cmd_d;
                        wdata_q    <= wdata_d;
                        ceN_q      <= 1'b0;
                        reqReady_q <= 1'b0;
                        state_q    <= ADDR;
                    end
                end

                ADDR: begin
`ifdef H80BUS_MASTER_TIMEOUT_EN
                    stallCount_q <= '0;
`endif
                    state_q <= ACCESS;
                end

                ACCESS: begin
                    // Normal completion takes priority over a timeout
                    // reached on the same edge.
                    if (bus.wait_n) begin
                        if (cmd_q[0]) begin
                            rdata_q <= rdata_d;
                        end
                        ceN_q      <= 1'b1;
                        rspValid_q <= 1'b1;
`ifdef H80BUS_MASTER_TIMEOUT_EN
                        rspErr_q   <= 1'b0;
`endif
                        state_q    <= RESP;
                    end
`ifdef H80BUS_MASTER_TIMEOUT_EN
                    else if (stallCount_q == CNT_LIMIT) begin
                        rdata_q    <= '0;
                        ceN_q      <= 1'b1;
                        rspValid_q <= 1'b1;
                        rspErr_q   <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        stallCount_q <= stallCount_q + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    rspValid_q <= 1'b0;
                    reqReady_q <= 1'b1;
`ifdef H80BUS_MASTER_TIMEOUT_EN
                    rspErr_q   <= 1'b0;
`endif
                    state_q    <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = reqReady_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.ce_n      = ceN_q;
    assign bus.addr      = addr_q;
    assign bus.cmd       = cmd_q;

`ifdef H80BUS_MASTER_TIMEOUT_EN
    assign bus.rsp_err = rspErr_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // The master drives data_ only during a write access. It releases the
    // bus on the same edge that raises ce_n, so it never drives at the same
    // time as a responder that answers a read.
    assign data_ = (!ceN_q && !cmd_q[0]) ? wdata_q : {BUS_DATA_WIDTH{1'bz}};

endmodule
